// File: rtl/dma_timing_ctrl.sv
// Active-cycle timing controller for one 8237A-style DMA channel.
// Owns the current/base address and count registers, detects terminal count,
// performs autoinitialize reload and sequences SI/S0/S1/S2/S3/S4.
// Optional build macro COMPRESSED_TIMING_EN: S3 is dropped and block transfers
// skip S1 while the upper address byte is unchanged.
module dma_timing_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              dreq,
    input  logic              hlda,
    input  logic              eop_in_n,
    input  logic [1:0]        xfer_type,
    input  logic              block_mode,
    input  logic              addr_dec,
    input  logic              autoinit,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  base_cnt,
    output logic              hrq,
    output logic              aen,
    output logic              adstb,
    output logic              ior,
    output logic              iow,
    output logic              memr,
    output logic              memw,
    output logic              eop,
    output logic [ADDR_W-1:0] addr_out,
    output logic              tc,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [CNT_W-1:0]    base_cnt_q, base_cnt_d;
    logic                ext_q, ext_d;
    logic                hrq_q, hrq_d;
    logic                aen_q, aen_d;
    logic                adstb_q, adstb_d;
    logic                ior_q, ior_d;
    logic                iow_q, iow_d;
    logic                memr_q, memr_d;
    logic                memw_q, memw_d;
    logic                eop_q, eop_d;
    logic                tc_q, tc_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_step;
    logic                is_wr;
    logic                is_rd;
`ifdef COMPRESSED_TIMING_EN
    logic                hi_chg_q, hi_chg_d;
`endif

    // Next state, register updates and registered output values
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        base_addr_d = base_addr_q;
        base_cnt_d  = base_cnt_q;
        ext_d       = ext_q;
`ifdef COMPRESSED_TIMING_EN
        hi_chg_d    = hi_chg_q;
`endif
        is_wr       = (xfer_type == 2'b01);
        is_rd       = (xfer_type == 2'b10);
        addr_step   = addr_dec ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));

        // External EOP is only observed while a transfer is on the bus
        if (((state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S3)) && !eop_in_n) begin
            ext_d = 1'b1;
        end

        case (state_q)
            ST_SI: begin
                if (base_load) begin
                    base_addr_d = base_addr;
                    base_cnt_d  = base_cnt;
                    addr_d      = base_addr;
                    cnt_d       = base_cnt;
                end
                if (dreq) begin
                    state_d = ST_S0;
                end
            end
            ST_S0: begin
                if (hlda) begin
                    state_d = ST_S1;
                end else if (!dreq) begin
                    state_d = ST_SI;
                end
            end
            ST_S1: state_d = ST_S2;
`ifdef COMPRESSED_TIMING_EN
            ST_S2: state_d = ST_S4;
`else
            ST_S2: state_d = ST_S3;
`endif
            ST_S3: state_d = ST_S4;
            ST_S4: begin
                if (tc_q || ext_q) begin
                    state_d = ST_SI;
                    if (autoinit) begin
                        addr_d = base_addr_q;
                        cnt_d  = base_cnt_q;
                    end
                end else if (!block_mode) begin
                    state_d = ST_SI;
                end else begin
`ifdef COMPRESSED_TIMING_EN
                    state_d = hi_chg_q ? ST_S1 : ST_S2;
`else
                    state_d = ST_S1;
`endif
                end
            end
            default: state_d = ST_SI;
        endcase

        // Counters step as the transfer enters S4
        if (state_d == ST_S4) begin
            addr_d = addr_step;
            cnt_d  = cnt_q - CNT_W'(1);
`ifdef COMPRESSED_TIMING_EN
            hi_chg_d = (addr_step[ADDR_W-1:8] != addr_q[ADDR_W-1:8]);
`endif
        end

        if (state_d == ST_SI) begin
            ext_d = 1'b0;
        end

        hrq_d   = (state_d != ST_SI);
        busy_d  = (state_d != ST_SI);
        aen_d   = (state_d == ST_S1) || (state_d == ST_S2) ||
                  (state_d == ST_S3) || (state_d == ST_S4);
        adstb_d = (state_d == ST_S1);
        ior_d   = 1'b1;
        iow_d   = 1'b1;
        memr_d  = 1'b1;
        memw_d  = 1'b1;
        if (state_d == ST_S2) begin
            ior_d  = !is_wr;
            memr_d = !is_rd;
`ifdef COMPRESSED_TIMING_EN
            iow_d  = !is_rd;
            memw_d = !is_wr;
`endif
        end
        if (state_d == ST_S3) begin
            ior_d  = !is_wr;
            memr_d = !is_rd;
            iow_d  = !is_rd;
            memw_d = !is_wr;
        end
        tc_d  = (state_d == ST_S4) && (cnt_q == '0);
        eop_d = !tc_d;
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_SI;
            addr_q      <= '0;
            cnt_q       <= '0;
            base_addr_q <= '0;
            base_cnt_q  <= '0;
            ext_q       <= 1'b0;
            hrq_q       <= 1'b0;
            aen_q       <= 1'b0;
            adstb_q     <= 1'b0;
            ior_q       <= 1'b1;
            iow_q       <= 1'b1;
            memr_q      <= 1'b1;
            memw_q      <= 1'b1;
            eop_q       <= 1'b1;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
`ifdef COMPRESSED_TIMING_EN
            hi_chg_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            base_addr_q <= base_addr_d;
            base_cnt_q  <= base_cnt_d;
            ext_q       <= ext_d;
            hrq_q       <= hrq_d;
            aen_q       <= aen_d;
            adstb_q     <= adstb_d;
            ior_q       <= ior_d;
            iow_q       <= iow_d;
            memr_q      <= memr_d;
            memw_q      <= memw_d;
            eop_q       <= eop_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
`ifdef COMPRESSED_TIMING_EN
            hi_chg_q    <= hi_chg_d;
`endif
        end
    end

    assign hrq      = hrq_q;
    assign aen      = aen_q;
    assign adstb    = adstb_q;
    assign ior      = ior_q;
    assign iow      = iow_q;
    assign memr     = memr_q;
    assign memw     = memw_q;
    assign eop      = eop_q;
    assign tc       = tc_q;
    assign busy     = busy_q;
    assign addr_out = addr_q;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Bench for dma_timing_ctrl: transaction-level trace model plus literal checks.
module tb_dma_timing_ctrl;

`ifdef COMPRESSED_TIMING_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        dreq, hlda, eop_in_n, block_mode, addr_dec, autoinit, base_load;
    logic [1:0]  xfer_type;
    logic [15:0] base_addr, base_cnt;
    logic        hrq, aen, adstb, ior, iow, memr, memw, eop, tc, busy;
    logic [15:0] addr_out;

    dma_timing_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .dreq(dreq), .hlda(hlda), .eop_in_n(eop_in_n),
        .xfer_type(xfer_type), .block_mode(block_mode), .addr_dec(addr_dec),
        .autoinit(autoinit), .base_load(base_load), .base_addr(base_addr),
        .base_cnt(base_cnt), .hrq(hrq), .aen(aen), .adstb(adstb), .ior(ior),
        .iow(iow), .memr(memr), .memw(memw), .eop(eop), .addr_out(addr_out),
        .tc(tc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic hrq, aen, adstb, ior, iow, memr, memw, eop, tc, busy;
        logic [15:0] addr;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] ex;
    } lit_t;

    obs_t        exp_q[$];
    lit_t        lit_q[$];
    obs_t        obs, e;
    lit_t        l;
    int          n_chk = 0;
    int          n_fail = 0;
    int          step_no = 0;
    logic [15:0] tc_log[$];
    logic [15:0] adstb_log[$];
    int          aen_cnt = 0;
    int          low_cnt = 0;

    // Channel model state
    logic [15:0] m_addr, m_cnt, m_base_addr, m_base_cnt;

    assign obs = {hrq, aen, adstb, ior, iow, memr, memw, eop, tc, busy, addr_out};

    // Single compare process: literal checks and the per-cycle trace
    always @(negedge CLK) begin
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            n_chk++;
            if (l.got !== l.ex) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", l.name, l.got, l.ex);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_no++;
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL trace step %0d: got hrq%b aen%b stb%b ior%b iow%b memr%b memw%b eop%b tc%b busy%b a=%h expected hrq%b aen%b stb%b ior%b iow%b memr%b memw%b eop%b tc%b busy%b a=%h",
                         step_no, obs.hrq, obs.aen, obs.adstb, obs.ior, obs.iow, obs.memr, obs.memw,
                         obs.eop, obs.tc, obs.busy, obs.addr, e.hrq, e.aen, e.adstb, e.ior, e.iow,
                         e.memr, e.memw, e.eop, e.tc, e.busy, e.addr);
            end
        end
    end

    // Event logs used by the literal checks
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (tc)    tc_log.push_back(addr_out);
            if (adstb) adstb_log.push_back(addr_out);
            if (aen)   aen_cnt++;
            if (!(ior && iow && memr && memw)) low_cnt++;
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] ex);
        lit_t t;
        t.name = nm;
        t.got  = got;
        t.ex   = ex;
        lit_q.push_back(t);
    endtask

    task automatic chk_log(input string nm, input logic [15:0] lg[$], input int from,
                           input logic [15:0] ex[$]);
        lit({nm, "_count"}, 32'(lg.size() - from), 32'(ex.size()));
        for (int i = 0; i < ex.size(); i++) begin
            if (from + i < lg.size()) lit(nm, 32'(lg[from + i]), 32'(ex[i]));
        end
    endtask

    function automatic obs_t mk(bit act, bit en, bit stb, bit r_io, bit w_io, bit r_m,
                                bit w_m, bit t, logic [15:0] a);
        obs_t o;
        o.hrq = act; o.aen = en; o.adstb = stb; o.ior = r_io; o.iow = w_io;
        o.memr = r_m; o.memw = w_m; o.eop = !t; o.tc = t; o.busy = act; o.addr = a;
        return o;
    endfunction

    // Whole DMA cycle as an expected per-cycle trace, from the channel's rules
    task automatic build_trace(input int k_s0, input int ext_xfer, output int ext_idx);
        obs_t        tr[$];
        logic [15:0] a, na;
        bit          rd, wr, tcx, need_s1;
        int          xf;
        rd = (xfer_type == 2'b10);
        wr = (xfer_type == 2'b01);
        ext_idx = -1;
        tr.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, m_addr));
        for (int i = 0; i < k_s0; i++) tr.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, m_addr));
        need_s1 = 1'b1;
        xf = 0;
        forever begin
            a = m_addr;
            if (need_s1 || !COMP) tr.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, a));
            if (xf == ext_xfer) ext_idx = tr.size();
            tr.push_back(mk(1, 1, 0, !wr, COMP ? !rd : 1'b1, !rd, COMP ? !wr : 1'b1, 0, a));
            if (!COMP) tr.push_back(mk(1, 1, 0, !wr, !rd, !rd, !wr, 0, a));
            na  = addr_dec ? a - 16'd1 : a + 16'd1;
            tcx = (m_cnt == 16'd0);
            tr.push_back(mk(1, 1, 0, 1, 1, 1, 1, tcx, na));
            m_cnt  = m_cnt - 16'd1;
            m_addr = na;
            if (tcx || xf == ext_xfer) begin
                if (autoinit) begin
                    m_addr = m_base_addr;
                    m_cnt  = m_base_cnt;
                end
                break;
            end
            if (!block_mode) break;
            need_s1 = (na[15:8] != a[15:8]);
            xf++;
        end
        tr.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, m_addr));
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] c);
        @(posedge CLK); #1;
        base_addr = a; base_cnt = c; base_load = 1'b1;
        @(posedge CLK); #1;
        base_load = 1'b0;
        m_addr = a; m_cnt = c; m_base_addr = a; m_base_cnt = c;
    endtask

    task automatic cfg(input logic [1:0] t, input bit blk, input bit dec, input bit ai);
        @(posedge CLK); #1;
        xfer_type = t; block_mode = blk; addr_dec = dec; autoinit = ai;
    endtask

    // One DMA cycle: dreq, hlda after k_s0 cycles, optional EOP and ignored base_load
    task automatic run_dma(input int k_s0, input int ext_xfer, input bit poke);
        int  idx;
        bit  done;
        @(posedge CLK); #1;
        build_trace(k_s0, ext_xfer, idx);
        dreq = 1'b1;
        if (poke) begin
            base_addr = 16'hBEEF;
            base_cnt  = 16'h0007;
        end
        done = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge CLK); #1;
            if (c == k_s0) hlda = 1'b1;
            if (c == k_s0 + 1) dreq = 1'b0;
            base_load = poke && (c == k_s0 + 1);
            eop_in_n  = !((idx >= 0) && (c == idx));
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            lit("run_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        hlda = 1'b0; base_load = 1'b0; eop_in_n = 1'b1; dreq = 1'b0;
    endtask

    logic [15:0] ex[$];
    int          tb0, ab0, en0, lo0;

    initial begin
        RESET_N = 1'b0; dreq = 0; hlda = 0; eop_in_n = 1; xfer_type = 2'b00;
        block_mode = 0; addr_dec = 0; autoinit = 0; base_load = 0;
        base_addr = '0; base_cnt = '0;
        m_addr = '0; m_cnt = '0; m_base_addr = '0; m_base_cnt = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        lit("rst_hrq", 32'(hrq), 32'd0);
        lit("rst_aen_adstb", 32'({aen, adstb}), 32'd0);
        lit("rst_strobes", 32'({ior, iow, memr, memw}), 32'hF);
        lit("rst_eop_tc_busy", 32'({eop, tc, busy}), 32'b100);
        lit("rst_addr", 32'(addr_out), 32'd0);

        // Single read, hlda two cycles after the request
        cfg(2'b10, 0, 0, 0);
        load(16'h1000, 16'd0);
        tb0 = tc_log.size(); ab0 = adstb_log.size();
        run_dma(2, -1, 0);
        ex = '{16'h1000};      chk_log("single_adstb", adstb_log, ab0, ex);
        ex = '{16'h1001};      chk_log("single_tc", tc_log, tb0, ex);
        lit("single_hrq_end", 32'(hrq), 32'd0);
        lit("single_addr_end", 32'(addr_out), 32'h1001);

        // Block write, decrementing through zero
        cfg(2'b01, 1, 1, 0);
        load(16'h0002, 16'd2);
        tb0 = tc_log.size(); ab0 = adstb_log.size(); en0 = aen_cnt;
        run_dma(1, -1, 0);
`ifdef COMPRESSED_TIMING_EN
        ex = '{16'h0002};
        lit("blkw_aen_cycles", 32'(aen_cnt - en0), 32'd7);
`else
        ex = '{16'h0002, 16'h0001, 16'h0000};
        lit("blkw_aen_cycles", 32'(aen_cnt - en0), 32'd12);
`endif
        chk_log("blkw_adstb", adstb_log, ab0, ex);
        ex = '{16'hFFFF};      chk_log("blkw_tc", tc_log, tb0, ex);
        lit("blkw_hrq_end", 32'(hrq), 32'd0);

        // Autoinit, with a base_load attempt mid-cycle that must be ignored
        cfg(2'b10, 1, 0, 1);
        load(16'h2000, 16'd1);
        for (int r = 0; r < 2; r++) begin
            tb0 = tc_log.size(); ab0 = adstb_log.size();
            run_dma(1, -1, r == 0);
`ifdef COMPRESSED_TIMING_EN
            ex = '{16'h2000};
`else
            ex = '{16'h2000, 16'h2001};
`endif
            chk_log("auto_adstb", adstb_log, ab0, ex);
            ex = '{16'h2002};  chk_log("auto_tc", tc_log, tb0, ex);
            lit("auto_addr_reload", 32'(addr_out), 32'h2000);
        end

        // External EOP in the second transfer, then resume the remaining count
        cfg(2'b10, 1, 0, 0);
        load(16'h3000, 16'd5);
        tb0 = tc_log.size();
        run_dma(1, 1, 0);
        lit("ext_no_tc", 32'(tc_log.size() - tb0), 32'd0);
        lit("ext_addr_end", 32'(addr_out), 32'h3002);
        tb0 = tc_log.size(); ab0 = adstb_log.size();
        run_dma(1, -1, 0);
`ifdef COMPRESSED_TIMING_EN
        ex = '{16'h3002};
`else
        ex = '{16'h3002, 16'h3003, 16'h3004, 16'h3005};
`endif
        chk_log("ext_resume_adstb", adstb_log, ab0, ex);
        ex = '{16'h3006};      chk_log("ext_resume_tc", tc_log, tb0, ex);

        // Illegal type behaves as verify: no strobes at all
        cfg(2'b11, 1, 0, 0);
        load(16'h4000, 16'd1);
        tb0 = tc_log.size(); lo0 = low_cnt;
        run_dma(1, -1, 0);
        lit("verify_no_strobe", 32'(low_cnt - lo0), 32'd0);
        ex = '{16'h4002};      chk_log("verify_tc", tc_log, tb0, ex);

        // Block read across the upper-byte boundary
        cfg(2'b10, 1, 0, 0);
        load(16'h10FE, 16'd3);
        tb0 = tc_log.size(); ab0 = adstb_log.size(); en0 = aen_cnt;
        run_dma(1, -1, 0);
`ifdef COMPRESSED_TIMING_EN
        ex = '{16'h10FE, 16'h1100};
        lit("cross_aen_cycles", 32'(aen_cnt - en0), 32'd10);
`else
        ex = '{16'h10FE, 16'h10FF, 16'h1100, 16'h1101};
        lit("cross_aen_cycles", 32'(aen_cnt - en0), 32'd16);
`endif
        chk_log("cross_adstb", adstb_log, ab0, ex);
        ex = '{16'h1102};      chk_log("cross_tc", tc_log, tb0, ex);

        // Request withdrawn in S0
        load(16'h5000, 16'd0);
        en0 = aen_cnt;
        @(posedge CLK); #1; dreq = 1'b1;
        @(posedge CLK); #1;
        lit("s0_hrq_busy", 32'({hrq, busy, aen}), 32'b110);
        @(posedge CLK); #1; dreq = 1'b0;
        @(posedge CLK); #1;
        lit("s0abort_hrq_busy", 32'({hrq, busy, aen, adstb}), 32'd0);
        lit("s0abort_strobes", 32'({ior, iow, memr, memw}), 32'hF);
        lit("s0abort_no_aen", 32'(aen_cnt - en0), 32'd0);
        lit("s0abort_addr", 32'(addr_out), 32'h5000);

        // Asynchronous reset in the middle of S2
        load(16'h6000, 16'd2);
        @(posedge CLK); #1; dreq = 1'b1;
        @(posedge CLK); #1; hlda = 1'b1;
        @(posedge CLK); #1; dreq = 1'b0;
        @(posedge CLK); #1;
        lit("s2_memr_aen", 32'({memr, aen}), 32'b01);
        #2;
        RESET_N = 1'b0;
        #1;
        lit("arst_strobes", 32'({ior, iow, memr, memw, eop}), 32'h1F);
        lit("arst_ctrl", 32'({hrq, aen, adstb, busy, tc}), 32'd0);
        lit("arst_addr", 32'(addr_out), 32'd0);
        hlda = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        lit("post_rst_idle", 32'({hrq, aen, busy}), 32'd0);

        repeat (3) @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- Active-cycle timing controller for one 8237A-style DMA channel.
- Sits directly upstream of the datapath. It generates the strobe and control values (ior, iow, memr, memw, eop, aen, adstb) that the datapath drives onto the bus during active cycles.
- Owns the current address and current word count registers, terminal count (TC) detection and autoinitialize reload.

Parameters:
- ADDR_W, 16, width of the address and base-address registers.
- CNT_W, 16, width of the word count and base-count registers.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- dreq  in  1  channel request, already polarity-corrected and unmasked.
- hlda  in  1  hold acknowledge from the CPU.
- eop_in_n  in  1  external EOP_N sampled from the pin, active low.
- xfer_type  in  2  00 verify, 01 write (I/O to mem), 10 read (mem to I/O), 11 illegal (treated as verify).
- block_mode  in  1  1 = block transfer, 0 = single transfer.
- addr_dec  in  1  1 = decrement address, 0 = increment.
- autoinit  in  1  reload from base registers on TC.
- base_load  in  1  CPU write strobe, loads base_addr/base_cnt into current and base registers.
- base_addr  in  ADDR_W  programmed start address.
- base_cnt  in  CNT_W  programmed count (transfers = base_cnt+1).
- hrq  out  1  hold request to the CPU.
- aen  out  1  address enable.
- adstb  out  1  address strobe (upper byte latch).
- ior, iow, memr, memw  out  1 each  active-low strobe values.
- eop  out  1  active-low internal EOP value.
- addr_out  out  ADDR_W  current address.
- tc  out  1  one-cycle terminal count pulse.
- busy  out  1  high in any state other than SI.

Behaviour:
- Reset:
  - state=SI, hrq=0, aen=0, adstb=0.
  - ior=iow=memr=memw=1, eop=1, tc=0.
  - Current and base registers = 0.
  - Reset asserted mid-transfer aborts immediately to these values.
- base_load is accepted only in SI. If asserted in any other state it is ignored.
- State machine: SI, S0, S1, S2, S3, S4.
  - SI: dreq=1 -> S0, with hrq=1 registered from the same edge.
  - S0: hold hrq=1. hlda=1 -> S1. dreq dropping before hlda -> SI, hrq=0.
  - S1: aen=1, adstb=1; addr_out valid.
  - S2: adstb=0.
    - write type: ior=0.
    - read type: memr=0.
    - verify: no strobes.
  - S3: write-side strobe asserted while the read-side strobe is held.
    - write type: memw=0.
    - read type: iow=0.
  - S4: all strobes return to 1.
    - Address: addr +/-1 per addr_dec; wraps modulo 2^ADDR_W.
    - Count: count-1.
    - If count was 0 before the decrement (wrap to all-ones): tc=1 and eop=0 for this cycle only.
- eop_in_n=0 sampled in S1, S2 or S3 latches an external-termination flag. The transfer still completes S4, then the cycle ends as if TC occurred, except the tc output stays 0.
- After S4:
  - TC or external terminate -> SI with hrq=0, aen=0. If autoinit=1, current address and count reload from the base registers in that S4 edge.
  - Single mode -> SI with hrq=0. A new request restarts from S0.
  - Block mode -> S1 (next transfer) with hrq held.
- aen stays 1 from S1 through S4 of every transfer in the cycle. It falls only on return to SI.
- Verify transfers step through all states and update the counters, but assert no strobes.
- dreq is not re-checked in block mode; it is only needed to start the cycle.

Optional Feature:
- COMPRESSED_TIMING_EN.
- Defined:
  - S3 is skipped: both strobes assert together in S2, S2 -> S4.
  - In block mode, S4 -> S2 directly when addr_out[ADDR_W-1:8] is unchanged by the increment/decrement; S1 (adstb) occurs only when the upper byte changes.
- Undefined: the full S1-S2-S3-S4 sequence is used for every transfer.

Test Plan:
- Single read:
  - Stimulus: base_addr=0x1000, base_cnt=0, xfer_type=10, dreq pulse, hlda after 2 cycles.
  - Required: S1 adstb=1, S2 memr=0, S3 iow=0, S4 tc=1 and eop=0, addr_out=0x1001, back to SI with hrq=0.
- Block write with decrement:
  - Stimulus: base_addr=0x0002, base_cnt=2, addr_dec=1.
  - Required: three transfers, addresses 0x0002, 0x0001, 0x0000, tc on the third S4, hrq released after it.
- Autoinit:
  - Stimulus: base_addr=0x2000, base_cnt=1, autoinit=1, block mode.
  - Required: after TC, addr_out=0x2000 and count=1 in SI; a second dreq repeats the identical sequence.
- External EOP:
  - Stimulus: block mode, base_cnt=5, eop_in_n=0 during the second transfer's S2.
  - Required: that transfer completes S4, then SI, tc never asserted, count=3.
- Reset mid-transfer and S0 abort:
  - Stimulus: RESET_N=0 in S2. Separately, drop dreq in S0.
  - Required:
    - Reset: strobes=1, aen=0, hrq=0 immediately (asynchronous), state SI.
    - S0 abort: return to SI with no strobes.
- With COMPRESSED_TIMING_EN:
  - Stimulus: block read at 0x10FE, base_cnt=3.
  - Required:
    - No S3 at any transfer.
    - adstb pulses only at the first transfer (0x10FE) and at 0x1100; the 0x10FF transfer goes S4 -> S2 without adstb.
